sdram_slot_arbiter: RTL and testbench

SDRAM_SLOT_ARBITER -- requirements
Module: sdram_slot_arbiter

---
 rtl/sdram_slot_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_slot_arbiter.sv
// Fixed-length SDRAM slot arbiter: one owner per slot, picked at the last cycle of the
// previous slot from chip/rtg/aud/cpu/host requests, with interleaved auto-refresh.
module sdram_slot_arbiter #(
    parameter int SLOT_CYCLES   = 8,
    parameter int RTG_MAX_RUN   = 4,
    parameter int REFRESH_SLOTS = 64,
    parameter int HOST_TIMEOUT  = 8
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       chip_req,
    input  logic       rtg_req,
    input  logic       rtgpri,
    input  logic       aud_req,
    input  logic       cpu_req,
    input  logic       host_req,
    output logic [4:0] grant,
    output logic       refresh,
    output logic       slot_first,
    output logic [5:0] slot_cnt
);

    localparam int             RFW        = (REFRESH_SLOTS > 1) ? $clog2(REFRESH_SLOTS) : 1;
    localparam logic [5:0]     LAST_CNT   = 6'(SLOT_CYCLES - 1);
    localparam logic [RFW-1:0] REF_LAST   = RFW'(REFRESH_SLOTS - 1);
    localparam logic [3:0]     RUN_LIMIT  = 4'(RTG_MAX_RUN);
    localparam logic [4:0]     HOST_LIMIT = 5'(HOST_TIMEOUT);

    typedef enum logic [2:0] {
        SEL_IDLE,
        SEL_REF,
        SEL_CHIP,
        SEL_RTG,
        SEL_RTGF,
        SEL_AUD,
        SEL_CPU,
        SEL_HOST
    } sel_e;

    logic [1:0]     r_sync;
    logic           r_rst_n;
    logic [5:0]     r_slot_cnt;
    logic           r_slot_first;
    logic [4:0]     r_grant;
    logic           r_refresh;
    logic [RFW-1:0] r_ref_cnt;
    logic           r_ref_due;
    logic           r_ref_post;
    logic [2:0]     r_rtg_run;
    logic [3:0]     r_host_wait;

    logic [5:0]     w_cnt_next;
    logic           w_decide;
    logic           w_rtg_ok;
    logic           w_host_late;
    logic           w_ref_wrap;
    sel_e           w_sel;
    logic [4:0]     w_grant_nxt;
    logic [2:0]     w_run_inc;
    logic [2:0]     w_run_nxt;
    logic [3:0]     w_hw_nxt;

    // Assert asynchronously, release two edges later. r_rst_n duplicates r_sync[1] so the
    // net used as an async reset is never also read as data.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= 2'b00;
            r_rst_n <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], 1'b1};
            r_rst_n <= r_sync[0];
        end
    end

    assign w_cnt_next = (r_slot_cnt == LAST_CNT) ? 6'd0 : r_slot_cnt + 6'd1;
    assign w_decide   = (r_slot_cnt == LAST_CNT);

    // Raised on the release edge itself so the very first slot after reset is flagged too.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n)
            r_slot_first <= 1'b0;
        else if (!r_sync[1])
            r_slot_first <= r_sync[0];
        else
            r_slot_first <= (w_cnt_next == 6'd0);
    end

    assign w_rtg_ok    = rtg_req && (rtgpri || ({1'b0, r_rtg_run} < RUN_LIMIT));
    assign w_host_late = ({1'b0, r_host_wait} >= HOST_LIMIT);
    assign w_ref_wrap  = (r_ref_cnt == REF_LAST);
    assign w_run_inc   = (r_rtg_run == 3'd7) ? r_rtg_run : r_rtg_run + 3'd1;

    always_comb begin
        w_sel = SEL_IDLE;
        if (r_ref_post)                 w_sel = SEL_REF;
        else if (chip_req)              w_sel = SEL_CHIP;
        else if (r_ref_due)             w_sel = SEL_REF;
        else if (w_rtg_ok)              w_sel = SEL_RTG;
        else if (aud_req)               w_sel = SEL_AUD;
        else if (host_req && w_host_late) w_sel = SEL_HOST;
        else if (cpu_req)               w_sel = SEL_CPU;
        else if (host_req)              w_sel = SEL_HOST;
        else if (rtg_req)               w_sel = SEL_RTGF;
    end

    always_comb begin
        w_grant_nxt = 5'b00000;
        w_run_nxt   = 3'd0;
        case (w_sel)
            SEL_CHIP: w_grant_nxt = 5'b00001;
            SEL_RTG: begin
                w_grant_nxt = 5'b00010;
                w_run_nxt   = rtgpri ? r_rtg_run : w_run_inc;
            end
            SEL_RTGF: begin
                w_grant_nxt = 5'b00010;
                w_run_nxt   = w_run_inc;
            end
            SEL_AUD:  w_grant_nxt = 5'b00100;
            SEL_CPU:  w_grant_nxt = 5'b01000;
            SEL_HOST: w_grant_nxt = 5'b10000;
            default:  w_grant_nxt = 5'b00000;
        endcase
        w_hw_nxt = 4'd0;
        if (host_req && (w_sel != SEL_HOST))
            w_hw_nxt = (r_host_wait == 4'd15) ? r_host_wait : r_host_wait + 4'd1;
    end

    always_ff @(posedge sysclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_slot_cnt  <= 6'd0;
            r_grant     <= 5'b00000;
            r_refresh   <= 1'b0;
            r_ref_cnt   <= '0;
            r_ref_due   <= 1'b0;
            r_ref_post  <= 1'b0;
            r_rtg_run   <= 3'd0;
            r_host_wait <= 4'd0;
        end else begin
            r_slot_cnt <= w_cnt_next;
            if (w_decide) begin
                r_grant     <= w_grant_nxt;
                r_refresh   <= (w_sel == SEL_REF);
                r_rtg_run   <= w_run_nxt;
                r_host_wait <= w_hw_nxt;
                r_ref_cnt   <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
                // A wrap while already due just leaves the single pending refresh in place.
                r_ref_due   <= (r_ref_due && (w_sel != SEL_REF)) || w_ref_wrap;
                r_ref_post  <= (w_sel != SEL_REF) &&
                               (r_ref_post || (r_ref_due && (w_sel == SEL_CHIP)));
            end
        end
    end

    assign grant      = r_grant;
    assign refresh    = r_refresh;
    assign slot_first = r_slot_first;
    assign slot_cnt   = r_slot_cnt;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: per-slot reference model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized request traffic.
module tb_sdram_slot_arbiter;

    localparam int SC     = 8;
    localparam int RMAX   = 4;
    localparam int RSLOTS = 64;
    localparam int HTO    = 8;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       chip_req = 1'b0, rtg_req = 1'b0, rtgpri = 1'b0;
    logic       aud_req = 1'b0, cpu_req = 1'b0, host_req = 1'b0;
    logic [4:0] grant;
    logic       refresh;
    logic       slot_first;
    logic [5:0] slot_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cur = 0;

    always #5 sysclk = ~sysclk;

    sdram_slot_arbiter #(
        .SLOT_CYCLES(SC), .RTG_MAX_RUN(RMAX), .REFRESH_SLOTS(RSLOTS), .HOST_TIMEOUT(HTO)
    ) dut (
        .sysclk(sysclk), .reset_n(reset_n),
        .chip_req(chip_req), .rtg_req(rtg_req), .rtgpri(rtgpri),
        .aud_req(aud_req), .cpu_req(cpu_req), .host_req(host_req),
        .grant(grant), .refresh(refresh), .slot_first(slot_first), .slot_cnt(slot_cnt)
    );

    // Reference model state: one decision per slot, plain integers.
    int         m_sync = 0, m_cnt = 0, m_refcnt = 0, m_run = 0, m_hw = 0;
    bit         m_due = 0, m_post = 0, m_first = 0, m_refresh = 0;
    logic [4:0] m_grant = 5'b0;

    task automatic m_decide();
        int w;
        if (m_post)                            w = 1;
        else if (chip_req)                     w = 2;
        else if (m_due)                        w = 1;
        else if (rtg_req && (rtgpri || m_run < RMAX)) w = 3;
        else if (aud_req)                      w = 5;
        else if (host_req && m_hw >= HTO)      w = 7;
        else if (cpu_req)                      w = 6;
        else if (host_req)                     w = 7;
        else if (rtg_req)                      w = 4;
        else                                   w = 0;
        case (w)
            2:       m_grant = 5'b00001;
            3, 4:    m_grant = 5'b00010;
            5:       m_grant = 5'b00100;
            6:       m_grant = 5'b01000;
            7:       m_grant = 5'b10000;
            default: m_grant = 5'b00000;
        endcase
        m_refresh = (w == 1);
        if ((w == 3 && !rtgpri) || w == 4) begin
            if (m_run < 7) m_run++;
        end else if (w != 3) m_run = 0;
        if (host_req && w != 7) begin
            if (m_hw < 15) m_hw++;
        end else m_hw = 0;
        if (w == 1) begin
            m_due = 0;
            m_post = 0;
        end else if (m_due && w == 2) m_post = 1;
        m_refcnt++;
        if (m_refcnt == RSLOTS) begin
            m_refcnt = 0;
            m_due = 1;
        end
    endtask

    initial forever begin
        @(posedge sysclk or negedge reset_n);
        if (!reset_n) begin
            m_sync = 0; m_cnt = 0; m_refcnt = 0; m_run = 0; m_hw = 0;
            m_due = 0; m_post = 0; m_first = 0; m_refresh = 0; m_grant = 5'b0;
        end else if (m_sync < 2) begin
            m_sync++;
            m_first = (m_sync == 2);
        end else begin
            if (m_cnt == SC - 1) m_decide();
            m_cnt = (m_cnt + 1) % SC;
            m_first = (m_cnt == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, exp);
        end
    endtask

    initial forever begin
        @(negedge sysclk);
        chk("grant", 32'(grant), 32'(m_grant));
        chk("refresh", 32'(refresh), 32'(m_refresh));
        chk("slot_first", 32'(slot_first), 32'(m_first));
        chk("slot_cnt", 32'(slot_cnt), 32'(m_cnt));
        chk("exclusive", 32'($countones({grant, refresh}) <= 1), 32'd1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    task automatic go(input int c);
        cyc(c - cur);
        cur = c;
    endtask

    // Reset with the given requests; returns 2 time units into cycle 0 (slot_cnt==0).
    task automatic start(input bit ch, input bit rt, input bit rp, input bit au,
                         input bit cp, input bit hs);
        @(posedge sysclk);
        #2;
        reset_n = 1'b0;
        chip_req = ch; rtg_req = rt; rtgpri = rp; aud_req = au; cpu_req = cp; host_req = hs;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        cur = 0;
    endtask

    initial begin
        // cpu only
        start(0, 0, 0, 0, 1, 0);
        go(7);  chk("s1_g7", 32'(grant), 32'h00); chk("s1_c7", 32'(slot_cnt), 32'd7);
        go(8);  chk("s1_g8", 32'(grant), 32'h08); chk("s1_f8", 32'(slot_first), 32'd1);
        go(13); chk("s1_g13", 32'(grant), 32'h08); chk("s1_c13", 32'(slot_cnt), 32'd5);
        go(40);

        // chip + cpu across the refresh wrap
        start(1, 0, 0, 0, 1, 0);
        go(8);   chk("s2_g8", 32'(grant), 32'h01);
        go(520); chk("s2_g520", 32'(grant), 32'h01); chk("s2_r520", 32'(refresh), 32'd0);
        go(528); chk("s2_r528", 32'(refresh), 32'd1); chk("s2_g528", 32'(grant), 32'h00);
        go(536); chk("s2_g536", 32'(grant), 32'h01);

        // rtg run limit, then priority rtg
        start(0, 1, 0, 0, 1, 0);
        go(32); chk("s3_g32", 32'(grant), 32'h02);
        go(40); chk("s3_g40", 32'(grant), 32'h08);
        go(48); chk("s3_g48", 32'(grant), 32'h02);
        rtgpri = 1'b1;
        go(80); chk("s3_g80", 32'(grant), 32'h02);
        go(96); chk("s3_g96", 32'(grant), 32'h02);
        rtgpri = 1'b0;
        go(160);

        // host timeout against cpu
        start(0, 0, 0, 0, 1, 1);
        go(64);  chk("s4_g64", 32'(grant), 32'h08);
        go(72);  chk("s4_g72", 32'(grant), 32'h10);
        go(80);  chk("s4_g80", 32'(grant), 32'h08);
        go(136); chk("s4_g136", 32'(grant), 32'h08);
        go(144); chk("s4_g144", 32'(grant), 32'h10);

        // mid-slot request pulse and mid-grant drop
        start(0, 0, 0, 0, 0, 0);
        go(10); cpu_req = 1'b1;
        go(12); cpu_req = 1'b0;
        go(16); chk("s5_g16", 32'(grant), 32'h00);
        go(22); cpu_req = 1'b1;
        go(24); chk("s5_g24", 32'(grant), 32'h08);
        go(26); cpu_req = 1'b0;
        go(31); chk("s5_g31", 32'(grant), 32'h08);
        go(32); chk("s5_g32", 32'(grant), 32'h00);

        // asynchronous reset in the middle of a chip slot
        start(1, 0, 0, 0, 0, 0);
        go(12); chk("s6_g12", 32'(grant), 32'h01); chk("s6_c12", 32'(slot_cnt), 32'd4);
        reset_n = 1'b0;
        #1;
        chk("s6_rg", 32'(grant), 32'h00); chk("s6_rc", 32'(slot_cnt), 32'd0);
        chk("s6_rf", 32'(slot_first), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        cur = 0;
        go(7); chk("s6_g7", 32'(grant), 32'h00);
        go(8); chk("s6_g8", 32'(grant), 32'h01);

        // randomized traffic with occasional resets
        start(0, 1, 0, 1, 1, 1);
        for (int i = 0; i < 4000; i++) begin
            cyc(1);
            if ($urandom_range(0, 3) == 0) chip_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) rtg_req  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) rtgpri  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) aud_req  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) cpu_req  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) host_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                cyc($urandom_range(1, 3));
                reset_n = 1'b1;
            end
        end
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
